eu_insn_fetch: RTL
==================

Name: eu_insn_fetch

Overview:
- Program sequencer in front of the EU instruction stream.
- On start, reads 32-bit instruction words from a program SRAM (fixed 1-cycle read latency) beginning at base_addr and pushes them to the EU insn valid/ready port.
- Frames each instruction by opcode word count, stops after OPC_END, and flags malformed programs.
- Keeps the EU fed back-to-back by prefetching into a 2-entry output FIFO.

Parameters:
INSN_W, 32, instruction word width
ADDR_W, 12, program memory word-address width
FIFO_DEPTH, 2, output FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin fetching at base_addr (ignored unless IDLE or DONE/ERR)
abort  in  1  pulse; flush and return to IDLE
base_addr  in  ADDR_W  first program word address, sampled on start
mem_req  out  1  SRAM read enable
mem_addr  out  ADDR_W  SRAM read address
mem_rdata  in  INSN_W  read data, valid the cycle after mem_req
insn_valid  out  1  to EU insn_valid
insn_ready  in  1  from EU insn_ready
insn_data  out  INSN_W  to EU insn_data
busy  out  1  high in FETCH or DRAIN
done  out  1  level; END word accepted by EU, cleared by start/abort
error_valid  out  1  level; cleared by start/abort
error_code  out  8  error cause
insn_cnt  out  16  instructions fully delivered since start, saturating
stall_cycles  out  32  perf counter (see Optional Feature)

Behaviour:
Reset values:
- All outputs 0; state IDLE; FIFO empty; internal address 0.
- Reset mid-operation discards in-flight read data.

States: IDLE, FETCH, DRAIN, DONE, ERR.
- IDLE/DONE/ERR: on start, latch addr=base_addr, clear done/error/insn_cnt/word_left, go to FETCH. Start in FETCH/DRAIN is ignored.
- FETCH issues mem_req with mem_addr=addr when occupancy + inflight < FIFO_DEPTH; addr increments per request.
- Returned words are pushed the cycle after mem_req. Steady state sustains 1 word/cycle with insn_ready held high.

Framing:
- word_left==0 marks a word as an opcode word; opcode = bits [7:0].
- OPC_NOP or OPC_END: length 1.
- OPC_CONV3X3, OPC_GEMM, OPC_POOL2D, OPC_UNPOOL2D, OPC_CONCAT_C, OPC_ACT_QUANT: length 8; word_left=7, decremented per arg word.
- Any other opcode: not pushed. Set error_code=ERR_INVALID_OPCODE (eu_isa_pkg), stop requests, discard any further in-flight word, go to DRAIN.
- OPC_END pushed: stop requests, discard in-flight word, go to DRAIN.

Address overflow:
- A request needed at addr wrap (previous request at 2^ADDR_W-1) sets error_code=8'hA0.
- No request is issued; go to DRAIN.

DRAIN:
- FIFO empties through the EU handshake.
- When empty: go to ERR with error_valid=1 if an error is pending, else go to DONE with done=1.
- done/error_valid assert the cycle after the last handshake.

Handshake and output:
- Transfer occurs on insn_valid && insn_ready.
- insn_valid = FIFO non-empty; insn_data = FIFO head, held stable while stalled.
- Push and pop in the same cycle when full is legal (occupancy unchanged).

insn_cnt:
- Increments on handshake of the last word of an instruction (an opcode word with length 1, or the 8th word).
- Saturates at 16'hFFFF.

abort (any state):
- Next cycle: IDLE, FIFO flushed, mem_req=0, in-flight data dropped, done/error_valid cleared, insn_cnt held.
- abort wins over a simultaneous start.

Optional Feature:
- Macro EU_FETCH_PERF_EN.
- Defined: stall_cycles counts cycles with insn_valid && !insn_ready, plus cycles in FETCH with FIFO empty. Cleared on start, saturating at 32'hFFFF_FFFF.
- Undefined: stall_cycles tied to 0, no counter logic.

Test Plan:
- Program at base 0x010: NOP, GEMM+7 args, END; insn_ready=1 -> 10 words delivered on consecutive cycles after 2-cycle start latency; insn_cnt=3; done=1 the cycle after END handshake; busy falls the same cycle.
- Same program, insn_ready toggling 1/0 every cycle -> identical word order; insn_data stable while stalled; never more than 2 outstanding words (FIFO+inflight).
- Word 0x0000_00EE at base (invalid opcode) -> no insn_valid; error_valid=1, error_code=ERR_INVALID_OPCODE; insn_cnt=0.
- base_addr=0xFFE, words CONV3X3,... -> after 2 words, no wrap request; the 2 words drain; error_code=8'hA0.
- abort asserted mid-GEMM args with FIFO full -> next cycle insn_valid=0, mem_req=0, state IDLE; subsequent start re-fetches cleanly from new base.
- EU_FETCH_PERF_EN defined, insn_ready held 0 for 5 cycles with FIFO non-empty -> stall_cycles increases by 5.

Source files
------------

// File: rtl/eu_insn_fetch.sv
// eu_insn_fetch: program sequencer that streams framed instruction words from
// a 1-cycle-latency program SRAM to the EU through a small prefetch FIFO.
// Optional stall performance counter enabled by defining EU_FETCH_PERF_EN.
module eu_insn_fetch #(
   parameter int INSN_W     = 32,
   parameter int ADDR_W     = 12,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [INSN_W-1:0] mem_rdata,
   output logic              insn_valid,
   input  logic              insn_ready,
   output logic [INSN_W-1:0] insn_data,
   output logic              busy,
   output logic              done,
   output logic              error_valid,
   output logic [7:0]        error_code,
   output logic [15:0]       insn_cnt,
   output logic [31:0]       stall_cycles
);
   localparam int PW = $clog2(FIFO_DEPTH);
   // EU ISA opcode and error encodings
   localparam logic [7:0] OPC_NOP            = 8'h00;
   localparam logic [7:0] OPC_END            = 8'h01;
   localparam logic [7:0] OPC_CONV3X3        = 8'h10;
   localparam logic [7:0] OPC_GEMM           = 8'h11;
   localparam logic [7:0] OPC_POOL2D         = 8'h12;
   localparam logic [7:0] OPC_UNPOOL2D       = 8'h13;
   localparam logic [7:0] OPC_CONCAT_C       = 8'h14;
   localparam logic [7:0] OPC_ACT_QUANT      = 8'h15;
   localparam logic [7:0] ERR_INVALID_OPCODE = 8'h01;
   localparam logic [7:0] ERR_ADDR_OVF       = 8'hA0;

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, DONE, ERR} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W:0]   addr;
   logic              inflight;
   logic [2:0]        word_left;
   logic [PW:0]       cnt, cnt_nxt;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [INSN_W:0]   fifo [FIFO_DEPTH];
   logic [7:0]        err_code;
   logic              pop, push, is_op, len1, len8, bad, is_end, last;
   logic              credit, want, ovf, start_ok, head_last;
   logic [7:0]        opc;

   assign insn_valid  = (cnt != '0);
   assign {head_last, insn_data} = fifo[rd_ptr];
   assign mem_addr    = addr[ADDR_W-1:0];
   assign busy        = (state == FETCH) || (state == DRAIN);
   assign done        = (state == DONE);
   assign error_valid = (state == ERR);
   assign error_code  = err_code;

   // Framing of the returning word, request credit and next-state selection
   always_comb begin
      pop       = insn_valid && insn_ready;
      opc       = mem_rdata[7:0];
      is_op     = (word_left == 3'd0);
      len1      = (opc == OPC_NOP) || (opc == OPC_END);
      len8      = opc inside {OPC_CONV3X3, OPC_GEMM, OPC_POOL2D, OPC_UNPOOL2D, OPC_CONCAT_C, OPC_ACT_QUANT};
      bad       = inflight && is_op && !len1 && !len8;
      is_end    = inflight && is_op && (opc == OPC_END);
      push      = inflight && !bad;
      last      = is_op ? len1 : (word_left == 3'd1);
      credit    = (32'(cnt) + 32'(inflight)) < (32'(FIFO_DEPTH) + 32'(pop));
      want      = (state == FETCH) && !abort && !bad && !is_end && credit;
      ovf       = want && addr[ADDR_W];
      mem_req   = want && !addr[ADDR_W];
      cnt_nxt   = cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      start_ok  = start && !abort && (state inside {IDLE, DONE, ERR});
      state_nxt = state;
      if (abort)
         state_nxt = IDLE;
      else if (start_ok)
         state_nxt = FETCH;
      else if (state == FETCH && (bad || is_end || ovf))
         state_nxt = DRAIN;
      else if (state == DRAIN && cnt_nxt == '0)
         state_nxt = (err_code != 8'd0 || bad) ? ERR : DONE;
   end

   // Sequencer state, address, framing, FIFO pointers and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= '0;
         inflight  <= 1'b0;
         word_left <= 3'd0;
         cnt       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         err_code  <= 8'd0;
         insn_cnt  <= 16'd0;
      end else begin
         state    <= state_nxt;
         inflight <= mem_req;
         if (abort) begin
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            word_left <= 3'd0;
            err_code  <= 8'd0;
         end else begin
            cnt <= cnt_nxt;
            if (push) begin
               wr_ptr    <= wr_ptr + 1'b1;
               word_left <= is_op ? (len8 ? 3'd7 : 3'd0) : word_left - 3'd1;
            end
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            if (mem_req)
               addr <= addr + 1'b1;
            if (bad && err_code == 8'd0)
               err_code <= ERR_INVALID_OPCODE;
            else if (ovf)
               err_code <= ERR_ADDR_OVF;
            if (start_ok) begin
               addr      <= {1'b0, base_addr};
               word_left <= 3'd0;
               err_code  <= 8'd0;
               insn_cnt  <= 16'd0;
            end else if (pop && head_last && insn_cnt != 16'hFFFF) begin
               insn_cnt <= insn_cnt + 16'd1;
            end
         end
      end
   end

   // FIFO storage: each entry carries its end-of-instruction flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            fifo[i] <= '0;
      end else if (push && !abort) begin
         fifo[wr_ptr] <= {last, mem_rdata};
      end
   end

`ifdef EU_FETCH_PERF_EN
   logic [31:0] stall_q;
   assign stall_cycles = stall_q;
   // Count cycles where the EU back-pressures or fetch starves the EU
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_q <= 32'd0;
      else if (start_ok)
         stall_q <= 32'd0;
      else if (((insn_valid && !insn_ready) || (state == FETCH && !insn_valid)) && stall_q != 32'hFFFF_FFFF)
         stall_q <= stall_q + 32'd1;
   end
`else
   assign stall_cycles = 32'd0;
`endif
endmodule
